// File: rtl/exec_muldiv.sv
// -----------------------------------------------------------------------------
// exec_muldiv
//   Iterative integer multiply/divide unit for the execute stage. It retires
//   STEP bits per cycle: shift-add for multiply and restoring division for
//   divide. Both datapaths work on operand magnitudes and fix the sign at the
//   end.
//
//   Build option:
//     MULDIV_DIV_EN  defined   -> all eight funct3 ops are implemented.
//                    undefined -> no divider datapath. Ops 4..7 complete in
//                                 one cycle with result=0 and illegal=1.
//
//   Ports:
//     clk       in   clock; all state changes on the rising edge
//     rstn      in   asynchronous active-low reset
//     start     in   request valid; sampled only in IDLE
//     op[2:0]   in   funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//     rs1_data  in   operand 1 (multiplier / dividend); latched on accept
//     rs2_data  in   operand 2 (multiplicand / divisor); latched on accept
//     flush     in   abort; returns to IDLE on the next edge without done
//     busy      out  high while iterating (pipeline stall)
//     done      out  one-cycle pulse; result is valid
//     result    out  registered result; held until the next done
//     illegal   out  valid with done; op is not supported in this build
// -----------------------------------------------------------------------------
module exec_muldiv #(
   parameter int XLEN = 32,
   parameter int STEP = 1
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            illegal
);

   localparam int NITER = XLEN / STEP;
   localparam int CW    = $clog2(NITER + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(NITER);
`ifdef MULDIV_DIV_EN
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
`endif

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t            r_state;
   logic [CW-1:0]     r_cnt;
   logic [2:0]        r_op;
   logic [XLEN-1:0]   r_hi;      // product high half / partial remainder
   logic [XLEN-1:0]   r_lo;      // multiplier bits / dividend-then-quotient
   logic [XLEN-1:0]   r_b;       // multiplicand / divisor magnitude
   logic              r_neg;     // negate the final magnitude
   logic              r_busy;
   logic              r_done;
   logic [XLEN-1:0]   r_result;
   logic              r_illegal;

   logic              w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_neg;
   logic [XLEN-1:0]   w_a_mag, w_b_mag;
   logic [XLEN:0]     w_sum;
   logic [XLEN-1:0]   w_hi_it, w_lo_it;
   logic [2*XLEN-1:0] w_prod, w_prod_s;
   logic [XLEN-1:0]   w_res;
`ifdef MULDIV_DIV_EN
   logic [XLEN:0]     w_rem;
   logic [XLEN-1:0]   w_dmag;
`endif

   assign busy    = r_busy;
   assign done    = r_done;
   assign result  = r_result;
   assign illegal = r_illegal;

   // Operand signedness by op, magnitudes and sign of the final result.
   always_comb begin
      w_a_sgn = 1'b0;
      w_b_sgn = 1'b0;
      case (op)
         3'd1: begin w_a_sgn = 1'b1; w_b_sgn = 1'b1; end
         3'd2: w_a_sgn = 1'b1;
`ifdef MULDIV_DIV_EN
         3'd4, 3'd6: begin w_a_sgn = 1'b1; w_b_sgn = 1'b1; end
`endif
         default: ;
      endcase
      w_a_neg = w_a_sgn & rs1_data[XLEN-1];
      w_b_neg = w_b_sgn & rs2_data[XLEN-1];
      w_a_mag = w_a_neg ? -rs1_data : rs1_data;
      w_b_mag = w_b_neg ? -rs2_data : rs2_data;
      // The remainder takes the dividend's sign; every other result takes the
      // xor of the operand signs.
      w_neg   = (op[2] & op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
   end

   // One CALC cycle: STEP single-bit iterations chained combinationally.
   always_comb begin
      w_sum   = '0;
      w_hi_it = r_hi;
      w_lo_it = r_lo;
`ifdef MULDIV_DIV_EN
      w_rem   = '0;
`endif
      for (int j = 0; j < STEP; j++) begin
`ifdef MULDIV_DIV_EN
         if (r_op[2]) begin
            // The partial remainder stays below the divisor, so bit XLEN of
            // the trial difference is exactly the borrow.
            w_rem   = {w_hi_it, w_lo_it[XLEN-1]};
            w_sum   = w_rem - {1'b0, r_b};
            w_hi_it = w_sum[XLEN] ? w_rem[XLEN-1:0] : w_sum[XLEN-1:0];
            w_lo_it = {w_lo_it[XLEN-2:0], ~w_sum[XLEN]};
         end else
`endif
         begin
            w_sum   = {1'b0, w_hi_it} + (w_lo_it[0] ? {1'b0, r_b} : '0);
            w_hi_it = w_sum[XLEN:1];
            w_lo_it = {w_sum[0], w_lo_it[XLEN-1:1]};
         end
      end
   end

   // Final result from the last iteration, with the sign applied.
   always_comb begin
      w_prod   = {w_hi_it, w_lo_it};
      w_prod_s = r_neg ? -w_prod : w_prod;
      w_res    = (r_op == 3'd0) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
      w_dmag   = r_op[1] ? w_hi_it : w_lo_it;
      if (r_op[2])
         w_res = r_neg ? -w_dmag : w_dmag;
`endif
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_op      <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_b       <= '0;
         r_neg     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_result  <= '0;
         r_illegal <= 1'b0;
      end else if (flush) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_op  <= op;
                  r_hi  <= '0;
                  r_lo  <= w_a_mag;
                  r_b   <= w_b_mag;
                  r_neg <= w_neg;
                  r_cnt <= CNT_INIT;
`ifdef MULDIV_DIV_EN
                  if (op[2] && rs2_data == '0) begin
                     r_state   <= S_DONE;
                     r_done    <= 1'b1;
                     r_result  <= op[1] ? rs1_data : '1;
                     r_illegal <= 1'b0;
                  end else if (op[2] && !op[0] && rs1_data == MOST_NEG && rs2_data == '1) begin
                     r_state   <= S_DONE;
                     r_done    <= 1'b1;
                     r_result  <= op[1] ? '0 : rs1_data;
                     r_illegal <= 1'b0;
                  end else begin
                     r_state <= S_CALC;
                     r_busy  <= 1'b1;
                  end
`else
                  if (op[2]) begin
                     r_state   <= S_DONE;
                     r_done    <= 1'b1;
                     r_result  <= '0;
                     r_illegal <= 1'b1;
                  end else begin
                     r_state <= S_CALC;
                     r_busy  <= 1'b1;
                  end
`endif
               end
            end
            S_CALC: begin
               r_hi  <= w_hi_it;
               r_lo  <= w_lo_it;
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CW'(1)) begin
                  r_state   <= S_DONE;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_result  <= w_res;
                  r_illegal <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exec_muldiv.sv
`timescale 1ns/1ps
module tb_exec_muldiv;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] rs1_data = '0;
   logic [31:0] rs2_data = '0;
   logic        busy, done, illegal;
   logic [31:0] result;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] last_exp = '0;

   exec_muldiv #(.XLEN(32), .STEP(1)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .start    (start),
      .op       (op),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .flush    (flush),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .illegal  (illegal)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one op, wait (bounded) for done, check result/illegal/latency.
   // Latency counts rising edges from the accept edge through the edge that
   // raises done.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_ill, input int exp_lat);
      int lat;
      int nbusy;
      op = o; rs1_data = a; rs2_data = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1; nbusy = 0;
      while (!done && lat < 100) begin
         if (busy) nbusy++;
         @(posedge clk); #1;
         lat++;
      end
      check_val("done_seen", done, 1'b1);
      check_val("busy_at_done", busy, 1'b0);
      check_val("result", result, exp_res);
      check_val("illegal", illegal, exp_ill);
      check_val("latency", lat, exp_lat);
      check_val("busy_cycles", nbusy, exp_lat - 1);
      $display("op=%0d rs1=%h rs2=%h -> result=%h illegal=%b latency=%0d busy=%0d",
               o, a, b, result, illegal, lat, nbusy);
      last_exp = exp_res;
      @(posedge clk); #1;
      check_val("done_pulse", done, 1'b0);
   endtask

   initial begin : stim
      int   lat;
      logic seen;

      // Reset values are forced asynchronously.
      #2;
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_done", done, 1'b0);
      check_val("rst_result", result, 32'h0);
      check_val("rst_illegal", illegal, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk) rstn = 1'b1;

      // First start goes in on the first rising edge after release.
      run_op(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33);
      run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 33);
      run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33);
      run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 33);
      run_op(3'd1, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 1'b0, 33);
      run_op(3'd3, 32'h12345678, 32'h00000010, 32'h00000001, 1'b0, 33);

`ifdef MULDIV_DIV_EN
      run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
      run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1);
      run_op(3'd5, 32'd100,      32'd0,        32'hFFFFFFFF, 1'b0, 1);
      run_op(3'd7, 32'd100,      32'd0,        32'h00000064, 1'b0, 1);
      run_op(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 33);
      run_op(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 33);
      run_op(3'd4, 32'd20,       32'hFFFFFFFA, 32'hFFFFFFFD, 1'b0, 33);
      run_op(3'd6, 32'd20,       32'hFFFFFFFA, 32'h00000002, 1'b0, 33);
      run_op(3'd7, 32'd10,       32'd3,        32'h00000001, 1'b0, 33);
`else
      run_op(3'd4, 32'd10,       32'd3,        32'h00000000, 1'b1, 1);
      run_op(3'd7, 32'd100,      32'd0,        32'h00000000, 1'b1, 1);
      run_op(3'd6, 32'hFFFFFFF9, 32'd2,        32'h00000000, 1'b1, 1);
`endif
      run_op(3'd0, 32'd6,        32'd7,        32'd42,       1'b0, 33);

      // Flush on CALC cycle 10: busy drops, no done, result held.
      op = 3'd0; rs1_data = 32'h1234; rs2_data = 32'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk); #1;
      check_val("calc10_busy", busy, 1'b1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check_val("flush_busy", busy, 1'b0);
      check_val("flush_done", done, 1'b0);
      check_val("flush_hold", result, last_exp);
      $display("flush during MUL: busy=%b done=%b result=%h", busy, done, result);
`ifdef MULDIV_DIV_EN
      run_op(3'd5, 32'd10, 32'd3, 32'd3, 1'b0, 33);
`else
      run_op(3'd5, 32'd10, 32'd3, 32'd0, 1'b1, 1);
`endif

      // Flush together with start in IDLE: nothing is accepted.
      op = 3'd0; rs1_data = 32'd3; rs2_data = 32'd3; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      check_val("fs_busy", busy, 1'b0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) seen = 1'b1;
      end
      check_val("fs_no_done", seen, 1'b0);
      $display("flush+start in IDLE: busy=%b done_seen=%b", busy, seen);

      // start held during CALC is ignored.
      op = 3'd0; rs1_data = 32'd6; rs2_data = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      op = 3'd3; rs1_data = 32'hFFFFFFFF; rs2_data = 32'hFFFFFFFF;
      repeat (5) @(posedge clk); #1;
      start = 1'b0;
      lat = 6;
      while (!done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check_val("ign_result", result, 32'd42);
      check_val("ign_latency", lat, 33);
      $display("start while busy: result=%h latency=%0d", result, lat);
      @(posedge clk); #1;

      // Reset mid-CALC clears everything immediately, no done afterwards.
      op = 3'd3; rs1_data = 32'hFFFFFFFF; rs2_data = 32'hFFFFFFFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk); #1;
      check_val("pre_rst_busy", busy, 1'b1);
      rstn = 1'b0;
      #1;
      check_val("mid_rst_busy", busy, 1'b0);
      check_val("mid_rst_done", done, 1'b0);
      check_val("mid_rst_result", result, 32'h0);
      check_val("mid_rst_illegal", illegal, 1'b0);
      seen = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done | busy) seen = 1'b1;
      end
      check_val("rst_quiet", seen, 1'b0);
      $display("reset mid-CALC: busy=%b done=%b result=%h", busy, done, result);
      @(negedge clk) rstn = 1'b1;
      run_op(3'd0, 32'd6, 32'd7, 32'd42, 1'b0, 33);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
